step_control_sequencer: RTL and testbench

//   Consumes the 3-bit step count (1..5) from the free-running step counter and the instruction register.

---
 rtl/ctrl_pkg.sv | 40 ++++
 rtl/step_decode.sv | 61 ++++++
 rtl/step_control_sequencer.sv | 135 +++++++++++++
 tb/tb_step_control_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared constants for the 5-step multicycle control sequencer:
// opcodes, ALU encodings, FSM state encoding and control-word bit layout.
package ctrl_pkg;

    // Instruction opcodes (IR top nibble); 8..15 are fetch-only NOPs
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_LD   = 4'd4;
    localparam logic [3:0] OP_ST   = 4'd5;
    localparam logic [3:0] OP_ADDI = 4'd6;
    localparam logic [3:0] OP_BR   = 4'd7;

    // ALU operation encodings
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    // Sequencer FSM states
    localparam logic [1:0] ST_SYNC  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_ERROR = 2'd2;

    // Control-word layout, MSB first
    localparam int CW_W       = 13;
    localparam int CW_PC_EN   = 12;
    localparam int CW_IR_EN   = 11;
    localparam int CW_RF_WR   = 10;
    localparam int CW_MEM_RD  = 9;
    localparam int CW_MEM_WR  = 8;
    localparam int CW_MUX_MA  = 7;
    localparam int CW_MUX_INC = 6;
    localparam int CW_MUX_B   = 5;
    localparam int CW_MUX_C   = 4;
    localparam int CW_MUX_Y   = 3;
    localparam int CW_ALU_LSB = 0;

endpackage

// File: rtl/step_decode.sv
// Combinational decoder: (step, opcode) -> control word for that step.
module step_decode
    import ctrl_pkg::*;
(
    input  logic [2:0]      step_i,
    input  logic [3:0]      opcode_i,
    output logic [CW_W-1:0] word_o
);

    // Build the control word for the requested step
    always_comb begin
        // NOTE: default every output first so no path leaves it unassigned (no latch).
        word_o = '0;
        case (step_i)
            3'd1: begin
                word_o[CW_MEM_RD] = 1'b1;
                word_o[CW_IR_EN]  = 1'b1;
                word_o[CW_PC_EN]  = 1'b1;
                word_o[CW_MUX_MA] = 1'b1;
            end
            3'd3: begin
                case (opcode_i)
                    OP_SUB:  word_o[CW_ALU_LSB +: 3] = ALU_SUB;
                    OP_AND:  word_o[CW_ALU_LSB +: 3] = ALU_AND;
                    OP_OR:   word_o[CW_ALU_LSB +: 3] = ALU_OR;
                    default: word_o[CW_ALU_LSB +: 3] = ALU_ADD;
                endcase
                if (opcode_i == OP_LD || opcode_i == OP_ST || opcode_i == OP_ADDI) begin
                    word_o[CW_MUX_B] = 1'b1;
                end
                if (opcode_i == OP_BR) begin
                    word_o[CW_PC_EN]   = 1'b1;
                    word_o[CW_MUX_INC] = 1'b1;
                end
            end
            3'd4: begin
                if (opcode_i == OP_LD) begin
                    word_o[CW_MEM_RD] = 1'b1;
                end
                if (opcode_i == OP_ST) begin
                    word_o[CW_MEM_WR] = 1'b1;
                end
            end
            3'd5: begin
                if (opcode_i == OP_ADD || opcode_i == OP_SUB ||
                    opcode_i == OP_AND || opcode_i == OP_OR) begin
                    word_o[CW_RF_WR] = 1'b1;
                end
                if (opcode_i == OP_ADDI || opcode_i == OP_LD) begin
                    word_o[CW_RF_WR] = 1'b1;
                    word_o[CW_MUX_C] = 1'b1;
                end
                if (opcode_i == OP_LD) begin
                    word_o[CW_MUX_Y] = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/step_control_sequencer.sv
// Step control sequencer: registers the control word one step ahead so it
// is valid for the whole step, checks the step sequence, counts retirements.
module step_control_sequencer
    import ctrl_pkg::*;
#(
    parameter int IR_W   = 24,
    parameter int ICNT_W = 16
)
(
    input  logic              Clock,
    input  logic              Reset,
    input  logic [2:0]        ClockCount,
    input  logic [IR_W-1:0]   IR,
    output logic              PC_enable,
    output logic              IR_enable,
    output logic              RF_write,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              MuxMA_sel,
    output logic              MuxINC_sel,
    output logic              MuxB_sel,
    output logic              MuxC_sel,
    output logic              MuxY_sel,
    output logic [2:0]        ALU_op,
    output logic [2:0]        Step,
    output logic              SeqError,
    output logic [ICNT_W-1:0] InstrCount
);

    logic [1:0]        state_q, state_d;
    logic [2:0]        step_q, step_d;
    logic [3:0]        op_q, op_d;
    logic [CW_W-1:0]   word_q, word_d;
    logic              seq_err_q, seq_err_d;
    logic [ICNT_W-1:0] icnt_q, icnt_d;

    logic [2:0]        nxt_step;
    logic [3:0]        ir_op;
    logic [3:0]        dec_op;
    logic [CW_W-1:0]   dec_word;
    logic              ir_low_unused;

    assign ir_op         = IR[IR_W-1 -: 4];
    assign ir_low_unused = ^IR[IR_W-5:0];
    assign nxt_step      = (ClockCount == 3'd5) ? 3'd1 : ClockCount + 3'd1;
    // The step-3 word needs the freshly loaded IR; later steps use the latched copy
    assign dec_op        = (nxt_step == 3'd3) ? ir_op : op_q;

    step_decode u_step_decode (
        .step_i   (nxt_step),
        .opcode_i (dec_op),
        .word_o   (dec_word)
    );

    // Next-state logic: sync to step 5, advance with sequence check, or hold in error
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        op_d      = op_q;
        word_d    = word_q;
        seq_err_d = seq_err_q;
        icnt_d    = icnt_q;
        case (state_q)
            ST_SYNC: begin
                if (ClockCount == 3'd5) begin
                    state_d = ST_RUN;
                    step_d  = 3'd1;
                    word_d  = dec_word;
                end
            end
            ST_RUN: begin
                if (ClockCount != step_q) begin
                    state_d   = ST_ERROR;
                    seq_err_d = 1'b1;
                    step_d    = 3'd0;
                    word_d    = '0;
                end else begin
                    step_d = nxt_step;
                    word_d = dec_word;
                    if (ClockCount == 3'd2) begin
                        op_d = ir_op;
                    end
                    if (ClockCount == 3'd5) begin
                        icnt_d = icnt_q + {{(ICNT_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            ST_ERROR: begin
                step_d = 3'd0;
                word_d = '0;
            end
            default: begin
                state_d = ST_SYNC;
                step_d  = 3'd0;
                word_d  = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset taking priority
    always_ff @(posedge Clock) begin
        // NOTE: registered state uses non-blocking (<=) so every flop samples pre-edge values.
        if (Reset) begin
            state_q   <= ST_SYNC;
            step_q    <= 3'd0;
            op_q      <= 4'd0;
            word_q    <= '0;
            seq_err_q <= 1'b0;
            icnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            op_q      <= op_d;
            word_q    <= word_d;
            seq_err_q <= seq_err_d;
            icnt_q    <= icnt_d;
        end
    end

    assign PC_enable  = word_q[CW_PC_EN];
    assign IR_enable  = word_q[CW_IR_EN];
    assign RF_write   = word_q[CW_RF_WR];
    assign MemRead    = word_q[CW_MEM_RD];
    assign MemWrite   = word_q[CW_MEM_WR];
    assign MuxMA_sel  = word_q[CW_MUX_MA];
    assign MuxINC_sel = word_q[CW_MUX_INC];
    assign MuxB_sel   = word_q[CW_MUX_B];
    assign MuxC_sel   = word_q[CW_MUX_C];
    assign MuxY_sel   = word_q[CW_MUX_Y];
    assign ALU_op     = word_q[CW_ALU_LSB +: 3];
    assign Step       = step_q;
    assign SeqError   = seq_err_q;
    assign InstrCount = icnt_q;

endmodule

// File: tb/tb_step_control_sequencer.sv
// Directed testbench for step_control_sequencer. A second instance with a
// 4-bit retire counter exercises counter wrap in a short run.
module tb_step_control_sequencer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [2:0]  ClockCount;
    logic [23:0] IR;

    logic        PC_enable, IR_enable, RF_write, MemRead, MemWrite;
    logic        MuxMA_sel, MuxINC_sel, MuxB_sel, MuxC_sel, MuxY_sel;
    logic [2:0]  ALU_op, Step;
    logic        SeqError;
    logic [15:0] InstrCount;

    logic        sm_pc_unused, sm_ir_unused, sm_rf_unused, sm_mr_unused, sm_mw_unused;
    logic        sm_ma_unused, sm_inc_unused, sm_b_unused, sm_c_unused, sm_y_unused;
    logic [2:0]  sm_alu_unused, sm_step_unused;
    logic        sm_SeqError;
    logic [3:0]  sm_InstrCount;

    // Strobe bundle, MSB first: PC IR RFW MR MW MA INC B C Y ALU[2:0]
    logic [12:0] strobes;
    assign strobes = {PC_enable, IR_enable, RF_write, MemRead, MemWrite, MuxMA_sel,
                      MuxINC_sel, MuxB_sel, MuxC_sel, MuxY_sel, ALU_op};

    localparam logic [12:0] W_ZERO  = 13'b0000000000000;
    localparam logic [12:0] W_STEP1 = 13'b1101010000000;
    localparam logic [12:0] W_LD_S3 = 13'b0000000100000;
    localparam logic [12:0] W_LD_S4 = 13'b0001000000000;
    localparam logic [12:0] W_LD_S5 = 13'b0010000011000;
    localparam logic [12:0] W_BR_S3 = 13'b1000001000000;
    localparam logic [12:0] W_ST_S4 = 13'b0000100000000;
    localparam logic [12:0] W_RR_S5 = 13'b0010000000000;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [15:0] exp_cnt;

    step_control_sequencer #(.IR_W(24), .ICNT_W(16)) dut (
        .Clock(Clock), .Reset(Reset), .ClockCount(ClockCount), .IR(IR),
        .PC_enable(PC_enable), .IR_enable(IR_enable), .RF_write(RF_write),
        .MemRead(MemRead), .MemWrite(MemWrite), .MuxMA_sel(MuxMA_sel),
        .MuxINC_sel(MuxINC_sel), .MuxB_sel(MuxB_sel), .MuxC_sel(MuxC_sel),
        .MuxY_sel(MuxY_sel), .ALU_op(ALU_op), .Step(Step),
        .SeqError(SeqError), .InstrCount(InstrCount)
    );

    step_control_sequencer #(.IR_W(24), .ICNT_W(4)) dut_small (
        .Clock(Clock), .Reset(Reset), .ClockCount(ClockCount), .IR(IR),
        .PC_enable(sm_pc_unused), .IR_enable(sm_ir_unused), .RF_write(sm_rf_unused),
        .MemRead(sm_mr_unused), .MemWrite(sm_mw_unused), .MuxMA_sel(sm_ma_unused),
        .MuxINC_sel(sm_inc_unused), .MuxB_sel(sm_b_unused), .MuxC_sel(sm_c_unused),
        .MuxY_sel(sm_y_unused), .ALU_op(sm_alu_unused), .Step(sm_step_unused),
        .SeqError(sm_SeqError), .InstrCount(sm_InstrCount)
    );

    always #5 Clock = ~Clock;

    // Apply a step count for one cycle; outputs are read 1 time unit after the edge
    task automatic tick(input logic [2:0] cc);
        ClockCount = cc;
        @(posedge Clock);
        #1;
    endtask

    task automatic set_op(input logic [3:0] op);
        IR = {op, 20'hABCDE};
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        set_op(4'd0);
        tick(3'd3); tick(3'd4); tick(3'd3);
        tests_run++; if (strobes !== W_ZERO) begin tests_failed++; $display("FAIL reset_strobes: got %b want %b", strobes, W_ZERO); end
        tests_run++; if (Step !== 3'd0) begin tests_failed++; $display("FAIL reset_step: got %0d want 0", Step); end
        tests_run++; if (SeqError !== 1'b0) begin tests_failed++; $display("FAIL reset_seqerr: got %b want 0", SeqError); end
        tests_run++; if (InstrCount !== 16'd0) begin tests_failed++; $display("FAIL reset_icnt: got %h want 0000", InstrCount); end
        Reset = 1'b0;
        tick(3'd3); tick(3'd4);
        tests_run++; if (strobes !== W_ZERO || Step !== 3'd0) begin tests_failed++; $display("FAIL sync_idle: got %b step %0d want %b step 0", strobes, Step, W_ZERO); end
        tick(3'd5);
        tests_run++; if (strobes !== W_STEP1) begin tests_failed++; $display("FAIL sync_step1_word: got %b want %b", strobes, W_STEP1); end
        tests_run++; if (Step !== 3'd1) begin tests_failed++; $display("FAIL sync_step1: got %0d want 1", Step); end
        exp_cnt = 16'd0;
    endtask

    task automatic test_load;
        set_op(4'd4);
        tick(3'd1);
        tests_run++; if (strobes !== W_ZERO || Step !== 3'd2) begin tests_failed++; $display("FAIL ld_s2: got %b step %0d want %b step 2", strobes, Step, W_ZERO); end
        tick(3'd2);
        tests_run++; if (strobes !== W_LD_S3 || Step !== 3'd3) begin tests_failed++; $display("FAIL ld_s3: got %b step %0d want %b step 3", strobes, Step, W_LD_S3); end
        tick(3'd3);
        tests_run++; if (strobes !== W_LD_S4) begin tests_failed++; $display("FAIL ld_s4: got %b want %b", strobes, W_LD_S4); end
        tick(3'd4);
        tests_run++; if (strobes !== W_LD_S5 || Step !== 3'd5) begin tests_failed++; $display("FAIL ld_s5: got %b step %0d want %b step 5", strobes, Step, W_LD_S5); end
        tests_run++; if (InstrCount !== exp_cnt) begin tests_failed++; $display("FAIL ld_icnt_before: got %h want %h", InstrCount, exp_cnt); end
        tick(3'd5);
        exp_cnt = exp_cnt + 16'd1;
        tests_run++; if (InstrCount !== exp_cnt) begin tests_failed++; $display("FAIL ld_icnt_after: got %h want %h", InstrCount, exp_cnt); end
        tests_run++; if (strobes !== W_STEP1) begin tests_failed++; $display("FAIL ld_next_fetch: got %b want %b", strobes, W_STEP1); end
    endtask

    task automatic test_branch;
        set_op(4'd7);
        tick(3'd1); tick(3'd2);
        tests_run++; if (strobes !== W_BR_S3) begin tests_failed++; $display("FAIL br_s3: got %b want %b", strobes, W_BR_S3); end
        tick(3'd3);
        tests_run++; if (strobes !== W_ZERO) begin tests_failed++; $display("FAIL br_s4: got %b want %b", strobes, W_ZERO); end
        tick(3'd4);
        tests_run++; if (strobes !== W_ZERO) begin tests_failed++; $display("FAIL br_s5: got %b want %b", strobes, W_ZERO); end
        tick(3'd5);
        exp_cnt = exp_cnt + 16'd1;
        tests_run++; if (InstrCount !== exp_cnt) begin tests_failed++; $display("FAIL br_icnt: got %h want %h", InstrCount, exp_cnt); end
    endtask

    task automatic test_opreg;
        set_op(4'd0);
        tick(3'd1); tick(3'd2);
        tests_run++; if (strobes !== W_ZERO || Step !== 3'd3) begin tests_failed++; $display("FAIL opreg_s3: got %b step %0d want %b step 3", strobes, Step, W_ZERO); end
        set_op(4'd5);
        tick(3'd3);
        tests_run++; if (strobes !== W_ZERO) begin tests_failed++; $display("FAIL opreg_s4_nowrite: got %b want %b", strobes, W_ZERO); end
        tick(3'd4);
        tests_run++; if (strobes !== W_RR_S5) begin tests_failed++; $display("FAIL opreg_s5: got %b want %b", strobes, W_RR_S5); end
        tick(3'd5);
        exp_cnt = exp_cnt + 16'd1;
        tests_run++; if (InstrCount !== exp_cnt) begin tests_failed++; $display("FAIL opreg_icnt: got %h want %h", InstrCount, exp_cnt); end
    endtask

    task automatic test_alu_ops;
        logic [3:0] ops [3];
        logic [2:0] alu_exp [3];
        ops[0] = 4'd1; alu_exp[0] = 3'b001;
        ops[1] = 4'd2; alu_exp[1] = 3'b010;
        ops[2] = 4'd3; alu_exp[2] = 3'b011;
        for (int i = 0; i < 3; i++) begin
            set_op(ops[i]);
            tick(3'd1); tick(3'd2);
            tests_run++; if (ALU_op !== alu_exp[i] || MuxB_sel !== 1'b0) begin tests_failed++; $display("FAIL alu_s3 op%0d: got alu %b b %b want alu %b b 0", ops[i], ALU_op, MuxB_sel, alu_exp[i]); end
            tick(3'd3); tick(3'd4);
            tests_run++; if (strobes !== W_RR_S5) begin tests_failed++; $display("FAIL alu_s5 op%0d: got %b want %b", ops[i], strobes, W_RR_S5); end
            tick(3'd5);
            exp_cnt = exp_cnt + 16'd1;
        end
        tests_run++; if (InstrCount !== exp_cnt) begin tests_failed++; $display("FAIL alu_icnt: got %h want %h", InstrCount, exp_cnt); end
    endtask

    task automatic test_mid_reset;
        set_op(4'd5);
        tick(3'd1); tick(3'd2);
        tests_run++; if (strobes !== W_LD_S3) begin tests_failed++; $display("FAIL st_s3: got %b want %b", strobes, W_LD_S3); end
        tick(3'd3);
        tests_run++; if (strobes !== W_ST_S4) begin tests_failed++; $display("FAIL st_s4: got %b want %b", strobes, W_ST_S4); end
        Reset = 1'b1;
        tick(3'd4);
        Reset = 1'b0;
        exp_cnt = 16'd0;
        tests_run++; if (strobes !== W_ZERO || Step !== 3'd0 || InstrCount !== 16'd0) begin tests_failed++; $display("FAIL midreset_clear: got %b step %0d icnt %h want zeros", strobes, Step, InstrCount); end
        tick(3'd5);
        tests_run++; if (strobes !== W_STEP1 || Step !== 3'd1) begin tests_failed++; $display("FAIL midreset_resync: got %b step %0d want %b step 1", strobes, Step, W_STEP1); end
    endtask

    task automatic test_seq_error;
        set_op(4'd0);
        tick(3'd1); tick(3'd2); tick(3'd3); tick(3'd4); tick(3'd5);
        exp_cnt = exp_cnt + 16'd1;
        tick(3'd1); tick(3'd2);
        tick(3'd4);
        tests_run++; if (SeqError !== 1'b1) begin tests_failed++; $display("FAIL seqerr_set: got %b want 1", SeqError); end
        tests_run++; if (strobes !== W_ZERO || Step !== 3'd0) begin tests_failed++; $display("FAIL seqerr_zero: got %b step %0d want %b step 0", strobes, Step, W_ZERO); end
        tests_run++; if (InstrCount !== exp_cnt) begin tests_failed++; $display("FAIL seqerr_icnt: got %h want %h", InstrCount, exp_cnt); end
        tick(3'd5); tick(3'd1); tick(3'd2); tick(3'd3); tick(3'd4); tick(3'd5);
        tests_run++; if (SeqError !== 1'b1 || strobes !== W_ZERO || InstrCount !== exp_cnt) begin tests_failed++; $display("FAIL seqerr_sticky: got err %b strobes %b icnt %h want 1 %b %h", SeqError, strobes, InstrCount, W_ZERO, exp_cnt); end
        Reset = 1'b1;
        tick(3'd5);
        Reset = 1'b0;
        exp_cnt = 16'd0;
        tests_run++; if (SeqError !== 1'b0 || InstrCount !== 16'd0) begin tests_failed++; $display("FAIL seqerr_reset: got err %b icnt %h want 0 0000", SeqError, InstrCount); end
        tick(3'd5);
        tick(3'd7);
        tests_run++; if (SeqError !== 1'b1 || strobes !== W_ZERO) begin tests_failed++; $display("FAIL illegal_cc7: got err %b strobes %b want 1 %b", SeqError, strobes, W_ZERO); end
    endtask

    task automatic test_wrap;
        Reset = 1'b1;
        set_op(4'd2);
        tick(3'd5);
        Reset = 1'b0;
        tick(3'd5);
        for (int i = 0; i < 15; i++) begin
            tick(3'd1); tick(3'd2); tick(3'd3); tick(3'd4); tick(3'd5);
        end
        tests_run++; if (sm_InstrCount !== 4'hF) begin tests_failed++; $display("FAIL wrap_at_max: got %h want f", sm_InstrCount); end
        tick(3'd1); tick(3'd2); tick(3'd3); tick(3'd4); tick(3'd5);
        tests_run++; if (sm_InstrCount !== 4'h0 || sm_SeqError !== 1'b0) begin tests_failed++; $display("FAIL wrap_to_zero: got %h err %b want 0 err 0", sm_InstrCount, sm_SeqError); end
        tests_run++; if (InstrCount !== 16'd16 || SeqError !== 1'b0) begin tests_failed++; $display("FAIL wrap_wide_count: got %h err %b want 0010 err 0", InstrCount, SeqError); end
    endtask

    initial begin
        Reset      = 1'b1;
        ClockCount = 3'd0;
        IR         = 24'h0;
        test_reset();
        test_load();
        test_branch();
        test_opreg();
        test_alu_ops();
        test_mid_reset();
        test_seq_error();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
